// File: rtl/trace_stream_serialiser_if.sv
// Trace-record input and AXI4-Stream output channels of the serialiser.
// "slave" is the serialiser's view; "master" is the surrounding
// producer/consumer environment.
interface trace_stream_serialiser_if;
    logic         trace_valid;
    logic         trace_ready;
    logic [127:0] trace_in;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tlast;

    modport slave (
        input  trace_valid, trace_in, m_axis_tready,
        output trace_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output trace_valid, trace_in, m_axis_tready,
        input  trace_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/trace_stream_serialiser.sv
// Buffers 128-bit trace records in a small FIFO and emits each one as a
// 4-beat, 32-bit AXI4-Stream packet (instruction, {instr_addr, mem_addr},
// time_start, time_end) with tlast on the fourth beat.
module trace_stream_serialiser #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    trace_stream_serialiser_if.slave      bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [COUNT_WIDTH-1:0]        records_sent_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_BEAT2,
        S_BEAT3
    } state_e;

    logic [127:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [LVL_W-1:0]       level_q;
    logic [LVL_W-1:0]       level_d;

    state_e                 state_q;
    logic [127:0]           hold_q;     // top word is always the beat on the bus
    logic                   tvalid_q;
    logic                   tlast_q;
    logic [COUNT_WIDTH-1:0] sent_q;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);

    // Ready depends only on the registered level, so a pop in the same
    // cycle never frees a slot early; it is held low throughout reset.
    assign bus.trace_ready = !rst && !fifo_full;
    assign push            = bus.trace_valid && !fifo_full;

    // Pop into the holding register when idle, or when the last beat of the
    // current record is accepted so the next packet follows with no bubble.
    assign pop = !fifo_empty &&
                 ((state_q == S_IDLE) ||
                  (state_q == S_BEAT3 && bus.m_axis_tready));

    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tdata  = hold_q[127:96];
    assign fifo_level_o      = level_q;
    assign records_sent_o    = sent_q;

    // Record storage write port.
    // NOTE: the storage array has no reset; only pointers and level need one,
    // and leaving the array unreset lets it map onto plain RAM/flop arrays.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.trace_in;
        end
    end

    // Next buffered-record count from this cycle's push/pop pair.
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Circular-buffer pointers and level; pointers wrap naturally at the
    // power-of-two depth.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Packet FSM: loads a record on pop, shifts one word per accepted beat,
    // and keeps tvalid/tdata/tlast registered and stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            sent_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        hold_q   <= mem_q[rd_ptr_q];
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        state_q  <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (bus.m_axis_tready) begin
                        hold_q  <= {hold_q[95:0], 32'h0};
                        state_q <= S_BEAT1;
                    end
                end
                S_BEAT1: begin
                    if (bus.m_axis_tready) begin
                        hold_q  <= {hold_q[95:0], 32'h0};
                        state_q <= S_BEAT2;
                    end
                end
                S_BEAT2: begin
                    if (bus.m_axis_tready) begin
                        hold_q  <= {hold_q[95:0], 32'h0};
                        tlast_q <= 1'b1;
                        state_q <= S_BEAT3;
                    end
                end
                S_BEAT3: begin
                    if (bus.m_axis_tready) begin
                        sent_q <= sent_q + 1'b1;
                        if (pop) begin
                            hold_q  <= mem_q[rd_ptr_q];
                            tlast_q <= 1'b0;
                            state_q <= S_BEAT0;
                        end else begin
                            hold_q   <= '0;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    hold_q   <= '0;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_stream_serialiser.sv
// Randomised bench for trace_stream_serialiser: records are turned into the
// expected beat list from their named fields, and captured stream beats are
// compared against that list in order.
module tb_trace_stream_serialiser;

    localparam int DEPTH = 4;
    localparam int CW    = 2;

    typedef struct packed {
        logic [31:0] instruction;
        logic [15:0] instr_addr;
        logic [15:0] mem_addr;
        logic [31:0] t_start;
        logic [31:0] t_end;
    } trace_rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    fifo_level;
    logic [CW-1:0] records_sent;

    trace_stream_serialiser_if bus ();

    trace_stream_serialiser #(
        .FIFO_DEPTH  (DEPTH),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .fifo_level_o   (fifo_level),
        .records_sent_o (records_sent)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int pushed = 0;     // records accepted since the last reset
    int chk_idx = 0;    // next expected beat to compare
    logic [32:0] exp_q [$];   // {last, data}
    logic [32:0] got_q [$];

    // Stream monitor: captures handshaked beats and counts protocol breaks.
    int   viol = 0;
    logic prev_valid, prev_ready, prev_last;
    logic [31:0] prev_data;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus.m_axis_tvalid === 1'b0 &&
                (bus.m_axis_tdata !== 32'h0 || bus.m_axis_tlast !== 1'b0))
                viol++;
            if (prev_valid && !prev_ready &&
                (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_data ||
                 bus.m_axis_tlast !== prev_last))
                viol++;
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1)
                got_q.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
            prev_valid = bus.m_axis_tvalid;
            prev_ready = bus.m_axis_tready;
            prev_data  = bus.m_axis_tdata;
            prev_last  = bus.m_axis_tlast;
        end
    end

    function automatic trace_rec_t rand_rec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Model: one record becomes four beats, tlast only on the last.
    function automatic void model_push(input trace_rec_t r);
        exp_q.push_back({1'b0, r.instruction});
        exp_q.push_back({1'b0, r.instr_addr, r.mem_addr});
        exp_q.push_back({1'b0, r.t_start});
        exp_q.push_back({1'b1, r.t_end});
        pushed++;
    endfunction

    // Offer a record until accepted (entered and left at posedge+1).
    task automatic push_rec(input trace_rec_t r);
        logic rdy;
        logic acc = 1'b0;
        bus.trace_in    = r;
        bus.trace_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            rdy = bus.trace_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                acc = 1'b1;
                break;
            end
        end
        bus.trace_valid = 1'b0;
        total++;
        if (acc) model_push(r);
        else begin
            bad++;
            $display("FAIL push_accept: got not accepted required accepted");
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while (got_q.size() < exp_q.size() && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.trace_valid   = 1'b0;
        bus.trace_in      = '0;
        bus.m_axis_tready = 1'b0;
        #3;
        total++;
        if (bus.trace_ready !== 1'b0 || bus.m_axis_tvalid !== 1'b0 ||
            bus.m_axis_tlast !== 1'b0 || bus.m_axis_tdata !== 32'h0 ||
            fifo_level !== 3'd0 || records_sent !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b v=%b l=%b d=%h lvl=%0d cnt=%0d required 0 0 0 0 0 0",
                     bus.trace_ready, bus.m_axis_tvalid, bus.m_axis_tlast,
                     bus.m_axis_tdata, fifo_level, records_sent);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.trace_ready !== 1'b1 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b lvl=%0d required rdy=1 lvl=0",
                     bus.trace_ready, fifo_level);
        end
    endtask

    task automatic test_single();
        trace_rec_t r = {32'h00A00093, 16'h0104, 16'h2000, 32'h00000010, 32'h00000015};
        bus.m_axis_tready = 1'b1;
        push_rec(r);
        total++;
        if (bus.m_axis_tvalid !== 1'b0 || fifo_level !== 3'd1) begin
            bad++;
            $display("FAIL single_push_edge: got v=%b lvl=%0d required v=0 lvl=1",
                     bus.m_axis_tvalid, fifo_level);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'h00A00093 ||
            bus.m_axis_tlast !== 1'b0 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL single_first_beat: got v=%b d=%h l=%b lvl=%0d required v=1 d=00a00093 l=0 lvl=0",
                     bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, fifo_level);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (records_sent !== 2'(pushed - 1)) begin
            bad++;
            $display("FAIL single_count_early: got %0d required %0d", records_sent, 2'(pushed - 1));
        end
        @(posedge clk);
        #1;
        total++;
        if (records_sent !== 2'(pushed) || bus.m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_done_5cyc: got cnt=%0d v=%b required cnt=%0d v=0",
                     records_sent, bus.m_axis_tvalid, 2'(pushed));
        end
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_beat[%0d]: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]);
            end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_backpressure();
        trace_rec_t r = rand_rec();
        int v0 = viol;
        bus.m_axis_tready = 1'b1;
        push_rec(r);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.m_axis_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== {r.instr_addr, r.mem_addr}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h required v=1 d=%h", k,
                         bus.m_axis_tvalid, bus.m_axis_tdata, {r.instr_addr, r.mem_addr});
            end
        end
        bus.m_axis_tready = 1'b1;
        wait_drain();
        total++;
        if (got_q.size() !== exp_q.size() || viol !== v0) begin
            bad++;
            $display("FAIL bp_count: got beats=%0d viol=%0d required beats=%0d viol=%0d",
                     got_q.size(), viol, exp_q.size(), v0);
        end
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_beat[%0d]: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]);
            end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_fill();
        trace_rec_t recs [6];
        int v0 = viol;
        for (int k = 0; k < 6; k++) recs[k] = rand_rec();
        bus.m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) push_rec(recs[k]);
        total++;
        if (fifo_level !== 3'd4 || bus.trace_ready !== 1'b0 ||
            bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== recs[0].instruction) begin
            bad++;
            $display("FAIL fill_full: got lvl=%0d rdy=%b v=%b d=%h required lvl=4 rdy=0 v=1 d=%h",
                     fifo_level, bus.trace_ready, bus.m_axis_tvalid, bus.m_axis_tdata,
                     recs[0].instruction);
        end
        bus.trace_in    = recs[5];
        bus.trace_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (fifo_level !== 3'd4 || bus.trace_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_stall: got lvl=%0d rdy=%b required lvl=4 rdy=0",
                     fifo_level, bus.trace_ready);
        end
        bus.m_axis_tready = 1'b1;
        push_rec(recs[5]);
        wait_drain();
        total++;
        if (got_q.size() !== exp_q.size() || viol !== v0 || records_sent !== 2'(pushed)) begin
            bad++;
            $display("FAIL fill_drain: got beats=%0d viol=%0d cnt=%0d required beats=%0d viol=%0d cnt=%0d",
                     got_q.size(), viol, records_sent, exp_q.size(), v0, 2'(pushed));
        end
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL fill_beat[%0d]: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]);
            end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_back_to_back();
        bus.m_axis_tready = 1'b0;
        for (int k = 0; k < 3; k++) push_rec(rand_rec());
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tlast !== ((i % 4) == 3)) begin
                bad++;
                $display("FAIL b2b_beat%0d: got v=%b l=%b required v=1 l=%b", i + 1,
                         bus.m_axis_tvalid, bus.m_axis_tlast, (i % 4) == 3);
            end
        end
        @(negedge clk);
        total++;
        if (bus.m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got v=%b required v=0", bus.m_axis_tvalid);
        end
        @(posedge clk);
        #1;
        wait_drain();
        total++;
        if (records_sent !== 2'(pushed)) begin
            bad++;
            $display("FAIL b2b_count: got %0d required %0d", records_sent, 2'(pushed));
        end
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_data[%0d]: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]);
            end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_reset_mid();
        trace_rec_t a = rand_rec();
        bus.m_axis_tready = 1'b0;
        push_rec(a);
        push_rec(rand_rec());
        bus.m_axis_tready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (bus.m_axis_tdata !== a.t_start || bus.m_axis_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL rmid_beat2: got v=%b d=%h required v=1 d=%h",
                     bus.m_axis_tvalid, bus.m_axis_tdata, a.t_start);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0 ||
            fifo_level !== 3'd0 || records_sent !== 2'd0) begin
            bad++;
            $display("FAIL rmid_async: got v=%b l=%b lvl=%0d cnt=%0d required 0 0 0 0",
                     bus.m_axis_tvalid, bus.m_axis_tlast, fifo_level, records_sent);
        end
        // Only BEAT0 and BEAT1 of record A reached the stream.
        repeat (6) void'(exp_q.pop_back());
        pushed = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rmid_partial: got beats=%0d required beats=%0d", got_q.size(), exp_q.size());
        end
        push_rec(rand_rec());
        wait_drain();
        total++;
        if (records_sent !== 2'd1) begin
            bad++;
            $display("FAIL rmid_count: got %0d required 1", records_sent);
        end
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rmid_beat[%0d]: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]);
            end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pushed = 0;
        @(posedge clk);
        #1;
        bus.m_axis_tready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push_rec(rand_rec());
            wait_drain();
            total++;
            if (records_sent !== 2'(k % (1 << CW))) begin
                bad++;
                $display("FAIL wrap_count%0d: got %0d required %0d", k, records_sent, k % (1 << CW));
            end
        end
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL wrap_beat[%0d]: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]);
            end
        end
        chk_idx = exp_q.size();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_stream_serialiser.md
Name: trace_stream_serialiser

Overview:
- Consumes packed trace_format records from the trace generator over a valid/ready handshake.
- Buffers records in a small FIFO.
- Emits each record as a 4-beat, 32-bit AXI4-Stream packet toward the host/DMA path.
- This is the reader/transmitter end of the trace_format interface.

Parameters:
FIFO_DEPTH, 4, record buffer depth; power of two, >= 2
COUNT_WIDTH, 16, width of the sent-record counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
trace_valid  in  1  trace_in holds a valid record
trace_ready  out  1  block can accept a record this cycle
trace_in  in  128  trace_format record: [127:96] instruction, [95:80] instr_addr, [79:64] mem_addr, [63:32] mem_trans_time_start, [31:0] mem_trans_time_end
m_axis_tvalid  out  1  stream beat valid
m_axis_tready  in  1  downstream accepts beat
m_axis_tdata  out  32  stream beat data
m_axis_tlast  out  1  final beat of a record
fifo_level  out  clog2(FIFO_DEPTH)+1  records currently buffered (excludes the record being serialised)
records_sent  out  COUNT_WIDTH  completed records, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE, outputs m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, records_sent=0, fifo_level=0, trace_ready=1 after reset deasserts (0 while rst high).
- Reset mid-packet: partial record discarded, no tlast emitted, FIFO contents lost.
- Push: on trace_valid && trace_ready.
  - trace_ready = !full, from registered state only.
  - No push when full even if a pop occurs the same cycle.
  - trace_valid while !trace_ready: record is not taken; producer must hold it.
- FIFO: circular, registered pointers with wrap at FIFO_DEPTH.
  - fifo_level updates +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- FSM states IDLE, BEAT0, BEAT1, BEAT2, BEAT3; 128-bit holding register loaded on pop.
  - IDLE: if FIFO non-empty, pop head into holding register, go to BEAT0. Otherwise stay.
  - BEATn (n=0..2): tvalid=1. On tvalid && tready, go to BEATn+1. Otherwise hold with tdata/tlast stable.
  - BEAT3: tvalid=1, tlast=1.
    - On handshake, records_sent+1.
    - If FIFO non-empty in that cycle, pop next record and go directly to BEAT0 (no bubble). Otherwise go to IDLE.
- Beat data:
  - BEAT0 = instruction.
  - BEAT1 = {instr_addr, mem_addr}.
  - BEAT2 = mem_trans_time_start.
  - BEAT3 = mem_trans_time_end.
- In IDLE: tvalid=0, tlast=0, tdata=0.
- Latency: record pushed into an empty, idle block at edge N is popped at edge N+1; first beat is valid after edge N+1. With tready tied high, a record completes in 5 cycles from push. Sustained throughput is 1 record per 4 cycles.
- tvalid never drops once asserted until its handshake (AXI4-Stream rule).
- records_sent wraps from 2^COUNT_WIDTH-1 to 0.

Test Plan:
- Single record: push {0x00A00093, 0x0104, 0x2000, 0x00000010, 0x00000015}, tready=1 → beats 0x00A00093, 0x01042000, 0x00000010, 0x00000015; tlast only on 4th beat; first tvalid 1 cycle after push; records_sent=1.
- Backpressure: tready low for 3 cycles during BEAT1 → tdata holds 0x01042000 with tvalid=1 throughout; no beat lost or duplicated.
- Fill: tready=0, push 5 records with FIFO_DEPTH=4 → 1 record in the holding register and 4 in the FIFO, fifo_level=4, trace_ready=0. The 6th record is stalled. Release tready → all 5 emitted in push order; trace_ready returns 1 after the first pop.
- Back-to-back: 3 records queued, tready=1 → 12 consecutive tvalid cycles with no IDLE gap; tlast on beats 4, 8, 12; records_sent=3.
- Reset mid-packet: assert rst during BEAT2 → tvalid, tlast and fifo_level go 0 immediately (asynchronously). After release, a new record is streamed cleanly from BEAT0.
- Counter wrap: COUNT_WIDTH=2, send 5 records → records_sent sequence 1, 2, 3, 0, 1.
